// File: rtl/sound_pkg.sv
// Shared types and constants for the square-wave tone synthesiser.
// HALF_PERIOD holds half-period lengths in 50 MHz cycles, chromatic from C4.
package sound_pkg;

    localparam int unsigned TONE_W   = 4;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned CNT_W    = 17;
    localparam int unsigned N_TONES  = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DRAIN
    } tone_state_t;

    // round(50e6 / (2 * f)), f = 440 * 2^((n-9)/12)
    localparam logic [CNT_W-1:0] HALF_PERIOD [N_TONES] = '{
        17'd95556, 17'd90193, 17'd85131, 17'd80353,
        17'd75843, 17'd71586, 17'd67569, 17'd63776,
        17'd60197, 17'd56818, 17'd53629, 17'd50619,
        17'd47778, 17'd45097, 17'd42566, 17'd40177
    };

    function automatic logic [CNT_W-1:0] reload_val(input logic [TONE_W-1:0] tone);
        return HALF_PERIOD[tone] - CNT_W'(1);
    endfunction

endpackage

// File: rtl/tone_fade_env.sv
// Linear attack/release envelope, stepped once per sample strobe and
// clamped to [0, AMPLITUDE].
module tone_fade_env
    import sound_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] AMPLITUDE = 16'd8192,
    parameter logic [SAMPLE_W-1:0] FADE_STEP = 16'd64
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                strobe_i,
    input  logic                attack_i,
    input  logic                release_i,
    output logic [SAMPLE_W-1:0] env_o,
    output logic [SAMPLE_W-1:0] env_next_c
);

    logic [SAMPLE_W-1:0] env_q;
    logic [SAMPLE_W-1:0] env_d;
    logic [SAMPLE_W:0]   sum_c;

    assign sum_c = {1'b0, env_q} + {1'b0, FADE_STEP};

    // Next envelope value; the sample path uses it so the first strobe already sees one step.
    always_comb begin
        env_d = env_q;
        if (strobe_i && attack_i) begin
            env_d = (sum_c > {1'b0, AMPLITUDE}) ? AMPLITUDE : sum_c[SAMPLE_W-1:0];
        end else if (strobe_i && release_i) begin
            env_d = (env_q > FADE_STEP) ? (env_q - FADE_STEP) : '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            env_q <= '0;
        end else begin
            env_q <= env_d;
        end
    end

    assign env_o      = env_q;
    assign env_next_c = env_d;

endmodule

// File: rtl/tone_square_gen.sv
// Square-wave tone generator: tone changes and stops take effect only at
// half-period boundaries. Define TONE_FADE_EN for a linear attack/release envelope.
module tone_square_gen
    import sound_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] AMPLITUDE = 16'd8192,
    parameter logic [SAMPLE_W-1:0] FADE_STEP = 16'd64
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                soundEnable,
    input  logic [TONE_W-1:0]   Tone,
    input  logic                sample_strobe,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                busy
);

    tone_state_t         state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [TONE_W-1:0]   cur_tone_q;
    logic [TONE_W-1:0]   cur_tone_d;
    logic                level_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic [SAMPLE_W-1:0] sample_d;
    logic                valid_q;
    logic                busy_q;

    logic                boundary_c;
    logic                load_c;
    logic                drain_exit_c;
    logic [CNT_W-1:0]    reload_c;
    logic [SAMPLE_W-1:0] amp_c;

    assign boundary_c = (cnt_q == '0);
    assign load_c     = (state_q == S_IDLE) ? soundEnable : boundary_c;
    assign cur_tone_d = load_c ? Tone : cur_tone_q;
    assign reload_c   = reload_val(cur_tone_d);

`ifdef TONE_FADE_EN
    logic [SAMPLE_W-1:0] env_q;
    logic [SAMPLE_W-1:0] env_next_c;

    tone_fade_env #(
        .AMPLITUDE (AMPLITUDE),
        .FADE_STEP (FADE_STEP)
    ) u_env (
        .clk        (clk),
        .resetN     (resetN),
        .strobe_i   (sample_strobe),
        .attack_i   (state_q == S_PLAY),
        .release_i  (state_q == S_DRAIN),
        .env_o      (env_q),
        .env_next_c (env_next_c)
    );

    assign amp_c        = env_next_c;
    assign drain_exit_c = (env_q == '0);
`else
    logic unused_fade_c;

    assign unused_fade_c = ^FADE_STEP;
    assign amp_c         = AMPLITUDE;
    assign drain_exit_c  = boundary_c;
`endif

    assign sample_d = (state_q == S_IDLE) ? '0
                    : (level_q ? amp_c : (~amp_c + SAMPLE_W'(1)));

    // Tone FSM, half-period counter and registered sample path.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_tone_q <= '0;
            level_q    <= 1'b1;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q    <= sample_strobe;
            cur_tone_q <= cur_tone_d;
            if (sample_strobe) begin
                sample_q <= sample_d;
            end

            if (state_q != S_IDLE) begin
                if (boundary_c) begin
                    level_q <= ~level_q;
                    cnt_q   <= reload_c;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q   <= '0;
                    level_q <= 1'b1;
                    if (soundEnable) begin
                        cnt_q   <= reload_c;
                        state_q <= S_PLAY;
                        busy_q  <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (!soundEnable) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (soundEnable) begin
                        state_q <= S_PLAY;
                    end else if (drain_exit_c) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_tone_square_gen.sv
// Self-checking bench for tone_square_gen: timeline vector table plus
// hand sequences for reset, drain and (with TONE_FADE_EN) the envelope.
module tb_tone_square_gen;

    localparam logic [15:0] POS  = 16'h2000;
    localparam logic [15:0] NEG  = 16'hE000;
    localparam logic [15:0] ZERO = 16'h0000;
    localparam int NV = 13;

    logic        clk;
    logic        resetN;
    logic        soundEnable;
    logic [3:0]  Tone;
    logic        sample_strobe;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;

    typedef struct {
        int unsigned at;
        logic        en;
        logic [3:0]  tone;
        logic        strobe;
        logic [15:0] exp_sample;
        logic        exp_busy;
    } vec_t;

    typedef struct {
        logic [15:0] val;
        int unsigned due;
    } sb_t;

    vec_t        vecs [NV];
    sb_t         sb [$];
    int unsigned cyc;
    int unsigned t0;
    int          n_tests;
    int          n_fail;

    tone_square_gen #(
        .AMPLITUDE (16'd8192),
        .FADE_STEP (16'd64)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .soundEnable   (soundEnable),
        .Tone          (Tone),
        .sample_strobe (sample_strobe),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance one clock; compare any sample that is due on this edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            n_tests++;
            if (sample_valid !== 1'b1 || sample_out !== sb[0].val) begin
                n_fail++;
                $display("FAIL sample @cyc %0d: valid=%b out=%h expected valid=1 out=%h",
                         cyc, sample_valid, sample_out, sb[0].val);
            end
            void'(sb.pop_front());
        end else if (sample_valid !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL stray_valid @cyc %0d: valid=%b expected 0", cyc, sample_valid);
        end
    endtask

    task automatic strobe_expect(input logic [15:0] v);
        sample_strobe = 1'b1;
        sb.push_back('{v, cyc + 1});
        tick();
        sample_strobe = 1'b0;
    endtask

    initial begin
        // at = sampling edge relative to the IDLE->PLAY edge; tone 15 = 40177, tone 14 = 42566
        vecs[0]  = '{1,     1'b1, 4'd15, 1'b1, POS,  1'b1};
        vecs[1]  = '{1042,  1'b1, 4'd15, 1'b1, POS,  1'b1};
        vecs[2]  = '{20000, 1'b1, 4'd14, 1'b1, POS,  1'b1};
        vecs[3]  = '{25000, 1'b0, 4'd14, 1'b1, POS,  1'b1};
        vecs[4]  = '{26000, 1'b1, 4'd14, 1'b1, POS,  1'b1};
        vecs[5]  = '{40177, 1'b1, 4'd14, 1'b1, POS,  1'b1};
        vecs[6]  = '{40178, 1'b1, 4'd14, 1'b1, NEG,  1'b1};
        vecs[7]  = '{60000, 1'b0, 4'd14, 1'b1, NEG,  1'b1};
        vecs[8]  = '{82742, 1'b0, 4'd14, 1'b1, NEG,  1'b1};
        vecs[9]  = '{82743, 1'b0, 4'd14, 1'b1, NEG,  1'b0};
        vecs[10] = '{82744, 1'b0, 4'd14, 1'b1, ZERO, 1'b0};
        vecs[11] = '{82800, 1'b1, 4'd9,  1'b0, ZERO, 1'b1};
        vecs[12] = '{82801, 1'b1, 4'd9,  1'b1, POS,  1'b1};

        cyc = 0;
        n_tests = 0;
        n_fail = 0;
        resetN = 1'b0;
        soundEnable = 1'b1;
        Tone = 4'd15;
        sample_strobe = 1'b0;

        tick();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        tick();
        check("reset_sample_out", 32'(sample_out), 32'd0);
        check("reset_valid", 32'(sample_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        resetN = 1'b1;
        t0 = cyc + 1;
        tick();
        check("busy_after_release", 32'(busy), 32'd1);

`ifdef TONE_FADE_EN
        for (int k = 1; k <= 130; k++) begin
            strobe_expect((k * 64 > 8192) ? 16'd8192 : 16'(k * 64));
            repeat (3) tick();
        end
        soundEnable = 1'b0;
        tick();
        check("fade_drain_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 128; k++) begin
            strobe_expect(16'(8192 - 64 * k));
            if (k < 128) repeat (3) tick();
        end
        check("fade_busy_at_zero", 32'(busy), 32'd1);
        tick();
        check("fade_busy_idle", 32'(busy), 32'd0);
        strobe_expect(ZERO);
        soundEnable = 1'b1;
        tick();
        strobe_expect(16'd64);
`else
        for (int i = 0; i < NV; i++) begin
            while (cyc + 1 < t0 + vecs[i].at) tick();
            soundEnable = vecs[i].en;
            Tone = vecs[i].tone;
            if (vecs[i].strobe) begin
                strobe_expect(vecs[i].exp_sample);
            end else begin
                tick();
            end
            check($sformatf("busy_row%0d", i), 32'(busy), 32'(vecs[i].exp_busy));
        end
`endif

        repeat (3) tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset while playing clears outputs without a clock edge.
        resetN = 1'b0;
        #2;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_sample", 32'(sample_out), 32'd0);
        check("async_reset_valid", 32'(sample_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
